// File: rtl/matrix_op_defs_pkg.sv
// Shared matrix-operator definitions: BRAM geometry, writer FSM states and
// the block metadata header packing.
package matrix_op_defs_pkg;

    localparam int MATRIX_DATA_WIDTH     = 32;
    localparam int MATRIX_ADDR_WIDTH     = 11;
    localparam int MATRIX_BLOCK_SIZE     = 256;
    localparam int MATRIX_METADATA_WORDS = 3;

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        META0,
        META1,
        META2,
        STREAM,
        FILL,
        DONE,
        ERR
    } matrix_writer_state_e;

    // Header word 0 of every block: rows in the top byte, cols below, low half reserved.
    function automatic logic [MATRIX_DATA_WIDTH-1:0] pack_matrix_header(
        input logic [7:0] rows,
        input logic [7:0] cols
    );
        return {rows, cols, 16'h0000};
    endfunction

endpackage

// File: rtl/matrix_block_writer.sv
// Commits one operator result (metadata header + row-major payload) into its
// matrix BRAM block. Optional tail clearing via MATRIX_WRITER_ZERO_FILL_EN.
module matrix_block_writer
    import matrix_op_defs_pkg::*;
#(
    parameter int DATA_WIDTH = MATRIX_DATA_WIDTH,
    parameter int ADDR_WIDTH = MATRIX_ADDR_WIDTH,
    parameter int BLOCK_SIZE = MATRIX_BLOCK_SIZE,
    parameter int META_WORDS = MATRIX_METADATA_WORDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_request,
    output logic                  write_ready,
    input  logic [2:0]            matrix_id,
    input  logic [7:0]            actual_rows,
    input  logic [7:0]            actual_cols,
    input  logic [7:0]            matrix_name [0:7],
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  writer_ready,
    output logic                  write_done,
    output logic                  write_error,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    output matrix_writer_state_e  state_dbg
);

    // Handshakes: a request is taken on any clock where write_request and
    // write_ready are both high; a payload beat is taken on any clock where
    // data_valid and writer_ready are both high. Nothing is queued otherwise.

    matrix_writer_state_e  state_q;
    logic [7:0]            rows_q;
    logic [7:0]            cols_q;
    logic [63:0]           name_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [15:0]           words_q;
    logic [15:0]           idx_q;

    logic                  oversize;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] elem_addr;
    matrix_writer_state_e  after_payload;

    assign oversize  = (32'(words_q) + 32'(META_WORDS)) > 32'(BLOCK_SIZE);
    assign last_beat = (idx_q + 16'd1) == words_q;
    assign elem_addr = base_q + ADDR_WIDTH'(META_WORDS) + ADDR_WIDTH'(idx_q);

`ifdef MATRIX_WRITER_ZERO_FILL_EN
    logic block_full;
    logic fill_last;

    // idx_q keeps counting past the payload so FILL reuses the element address path.
    assign block_full    = (32'(words_q) + 32'(META_WORDS)) == 32'(BLOCK_SIZE);
    assign fill_last     = (32'(idx_q) + 32'(META_WORDS) + 32'd1) >= 32'(BLOCK_SIZE);
    assign after_payload = block_full ? DONE : FILL;
`else
    assign after_payload = DONE;
`endif

    assign write_ready  = (state_q == IDLE);
    assign writer_ready = (state_q == STREAM);
    assign state_dbg    = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rows_q      <= '0;
            cols_q      <= '0;
            name_q      <= '0;
            base_q      <= '0;
            words_q     <= '0;
            idx_q       <= '0;
            write_done  <= 1'b0;
            write_error <= 1'b0;
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            bram_wdata  <= '0;
        end else begin
            write_done  <= 1'b0;
            write_error <= 1'b0;
            bram_we     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (write_request) begin
                        rows_q  <= actual_rows;
                        cols_q  <= actual_cols;
                        name_q  <= {matrix_name[0], matrix_name[1], matrix_name[2], matrix_name[3],
                                    matrix_name[4], matrix_name[5], matrix_name[6], matrix_name[7]};
                        base_q  <= ADDR_WIDTH'(matrix_id) * ADDR_WIDTH'(BLOCK_SIZE);
                        words_q <= 16'(actual_rows) * 16'(actual_cols);
                        idx_q   <= '0;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (oversize) begin
                        write_done  <= 1'b1;
                        write_error <= 1'b1;
                        state_q     <= ERR;
                    end else begin
                        state_q <= META0;
                    end
                end
                ERR: state_q <= IDLE;
                META0: begin
                    bram_we    <= 1'b1;
                    bram_addr  <= base_q;
                    bram_wdata <= DATA_WIDTH'(pack_matrix_header(rows_q, cols_q));
                    state_q    <= META1;
                end
                META1: begin
                    bram_we    <= 1'b1;
                    bram_addr  <= base_q + ADDR_WIDTH'(1);
                    bram_wdata <= DATA_WIDTH'(name_q[63:32]);
                    state_q    <= META2;
                end
                META2: begin
                    bram_we    <= 1'b1;
                    bram_addr  <= base_q + ADDR_WIDTH'(2);
                    bram_wdata <= DATA_WIDTH'(name_q[31:0]);
                    if (words_q != 16'd0) begin
                        state_q <= STREAM;
                    end else begin
                        state_q    <= after_payload;
                        write_done <= (after_payload == DONE);
                    end
                end
                STREAM: begin
                    if (data_valid) begin
                        bram_we    <= 1'b1;
                        bram_addr  <= elem_addr;
                        bram_wdata <= data_in;
                        idx_q      <= idx_q + 16'd1;
                        if (last_beat) begin
                            state_q    <= after_payload;
                            write_done <= (after_payload == DONE);
                        end
                    end
                end
`ifdef MATRIX_WRITER_ZERO_FILL_EN
                FILL: begin
                    bram_we    <= 1'b1;
                    bram_addr  <= elem_addr;
                    bram_wdata <= '0;
                    idx_q      <= idx_q + 16'd1;
                    if (fill_last) begin
                        write_done <= 1'b1;
                        state_q    <= DONE;
                    end
                end
`endif
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_block_writer.sv
// Self-checking bench for matrix_block_writer: directed jobs plus random jobs
// against a block-level memory model (MATRIX_WRITER_ZERO_FILL_EN aware).
module tb_matrix_block_writer;
    import matrix_op_defs_pkg::*;

    localparam int DW   = MATRIX_DATA_WIDTH;
    localparam int AW   = MATRIX_ADDR_WIDTH;
    localparam int BS   = MATRIX_BLOCK_SIZE;
    localparam int MW   = MATRIX_METADATA_WORDS;
    localparam int NBLK = 8;
`ifdef MATRIX_WRITER_ZERO_FILL_EN
    localparam bit ZERO_FILL = 1'b1;
`else
    localparam bit ZERO_FILL = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic                 clk;
    logic                 rst_n;
    logic                 write_request;
    logic                 write_ready;
    logic [2:0]           matrix_id;
    logic [7:0]           actual_rows;
    logic [7:0]           actual_cols;
    logic [7:0]           matrix_name [0:7];
    logic [DW-1:0]        data_in;
    logic                 data_valid;
    logic                 writer_ready;
    logic                 write_done;
    logic                 write_error;
    logic                 bram_we;
    logic [AW-1:0]        bram_addr;
    logic [DW-1:0]        bram_wdata;
    matrix_writer_state_e state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    matrix_block_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_request(write_request),
        .write_ready  (write_ready),
        .matrix_id    (matrix_id),
        .actual_rows  (actual_rows),
        .actual_cols  (actual_cols),
        .matrix_name  (matrix_name),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .writer_ready (writer_ready),
        .write_done   (write_done),
        .write_error  (write_error),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_wdata   (bram_wdata),
        .state_dbg    (state_dbg)
    );

    // ---------------- BRAM and event monitor ----------------
    logic [DW-1:0]    mem [0:NBLK*BS-1];
    logic [AW+DW-1:0] log_q[$];
    int               done_cnt;

    always @(posedge clk) begin
        if (bram_we === 1'b1) begin
            mem[bram_addr] <= bram_wdata;
            log_q.push_back({bram_addr, bram_wdata});
        end
        if (write_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0]    exp_mem [0:NBLK*BS-1];
    logic [AW+DW-1:0] exp_q[$];
    logic [7:0]       cur_name [0:7];
    logic [DW-1:0]    pay_q[$];
    int               checks;
    int               errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input int addr, input logic [DW-1:0] data);
        exp_q.push_back({AW'(addr), data});
        exp_mem[addr] = data;
    endtask

    task automatic model_header(input int base, input int rows, input int cols);
        model_write(base, DW'(rows * 32'h0100_0000 + cols * 32'h0001_0000));
        model_write(base + 1, DW'(cur_name[0] * 32'h0100_0000 + cur_name[1] * 32'h0001_0000 +
                                  cur_name[2] * 32'h0000_0100 + cur_name[3]));
        model_write(base + 2, DW'(cur_name[4] * 32'h0100_0000 + cur_name[5] * 32'h0001_0000 +
                                  cur_name[6] * 32'h0000_0100 + cur_name[7]));
    endtask

    task automatic model_job(input int id, input int rows, input int cols, output bit err);
        int words;
        int base;
        words = rows * cols;
        base  = id * BS;
        exp_q.delete();
        err = (words + MW > BS);
        if (!err) begin
            model_header(base, rows, cols);
            for (int i = 0; i < words; i++) model_write(base + MW + i, pay_q[i]);
            if (ZERO_FILL) for (int i = words; i < BS - MW; i++) model_write(base + MW + i, '0);
        end
    endtask

    task automatic set_name(input string s);
        for (int k = 0; k < 8; k++) cur_name[k] = (k < s.len()) ? s[k] : 8'h00;
    endtask

    task automatic check_block(input int id);
        int bad;
        bad = 0;
        for (int a = id * BS; a < (id + 1) * BS; a++) if (mem[a] !== exp_mem[a]) bad++;
        check($sformatf("block%0d_contents", id), bad, 0);
    endtask

    task automatic check_log(input int log_start, input string tag);
        int nlog;
        int bad;
        nlog = log_q.size() - log_start;
        check({tag, "_bram_we_cycles"}, nlog, exp_q.size());
        bad = 0;
        for (int i = 0; i < nlog && i < exp_q.size(); i++) if (log_q[log_start + i] !== exp_q[i]) bad++;
        check({tag, "_bram_write_seq"}, bad, 0);
    endtask

    // ---------------- driver ----------------
    task automatic run_job(input int id, input int rows, input int cols, input int gap,
                           input bit drain, output int wait_cnt);
        bit err;
        bit seen;
        int words;
        int cyc;
        int sent;
        int scyc;
        int log_start;
        int done_start;
        int exp_lat;
        words = rows * cols;
        model_job(id, rows, cols, err);
        matrix_id   = 3'(id);
        actual_rows = 8'(rows);
        actual_cols = 8'(cols);
        for (int k = 0; k < 8; k++) matrix_name[k] = cur_name[k];
        write_request = 1'b1;
        wait_cnt = 0;
        while (write_ready !== 1'b1 && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("request_accepted", write_ready, 1'b1);
        @(posedge clk);
        #1;
        write_request = 1'b0;
        matrix_id     = 3'($urandom);
        actual_rows   = 8'($urandom);
        actual_cols   = 8'($urandom);
        for (int k = 0; k < 8; k++) matrix_name[k] = 8'($urandom);
        log_start  = log_q.size();
        done_start = done_cnt;
        cyc = 0; sent = 0; scyc = 0; seen = 1'b0;
        while (!seen && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (write_done === 1'b1) begin
                seen = 1'b1;
            end else if (writer_ready === 1'b1 && sent < words) begin
                if (scyc % gap == 0) begin
                    data_valid = 1'b1;
                    data_in    = pay_q[sent];
                    sent++;
                end else begin
                    data_valid = 1'b0;
                    data_in    = DW'($urandom);
                end
                scyc++;
            end else begin
                data_valid = 1'($urandom_range(0, 1));
                data_in    = DW'($urandom);
            end
        end
        check("write_done_seen", seen, 1'b1);
        check("write_error", write_error, err);
        check("beats_before_done", sent, err ? 0 : words);
        if (gap == 1) begin
            exp_lat = err ? 2 : 5 + (ZERO_FILL ? BS - MW : words);
            check("done_latency", cyc, exp_lat);
        end
        if (drain) begin
            data_valid = 1'b0;
            @(negedge clk);
            check("done_pulse_width", write_done, 1'b0);
            check("write_ready_after_done", write_ready, 1'b1);
            @(negedge clk);
            check("done_count", done_cnt - done_start, 1);
            check_log(log_start, "job");
            check_block(id);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int w2;
        int id;
        int r;
        int c;
        int g;
        int sent;
        int cyc;
        int log_start;
        int done_start;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        write_request = 1'b0;
        data_valid = 1'b0;
        data_in = '0;
        matrix_id = '0;
        actual_rows = '0;
        actual_cols = '0;
        for (int k = 0; k < 8; k++) matrix_name[k] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_write_ready", write_ready, 1'b1);
        check("rst_writer_ready", writer_ready, 1'b0);
        check("rst_write_done", write_done, 1'b0);
        check("rst_write_error", write_error, 1'b0);
        check("rst_bram_we", bram_we, 1'b0);
        check("rst_bram_addr", bram_addr, '0);
        check("rst_bram_wdata", bram_wdata, '0);
        check("rst_state", state_dbg, IDLE);
        rst_n = 1'b1;
        @(negedge clk);

        // 2x2 "SRC" into block 2, back-to-back then gapped payload
        set_name("SRC");
        pay_q = '{32'd3, 32'd6, 32'd9, 32'd12};
        run_job(2, 2, 2, 1, 1'b1, w);
        check("src_hdr0", mem[2*BS], 32'h0202_0000);
        check("src_hdr1", mem[2*BS+1], 32'h5352_4300);
        check("src_hdr2", mem[2*BS+2], 32'h0000_0000);
        check("src_elem3", mem[2*BS+6], 32'd12);
        run_job(2, 2, 2, 3, 1'b1, w);
        check("gap_elem0", mem[2*BS+3], 32'd3);
        check("gap_elem3", mem[2*BS+6], 32'd12);

        // oversize request must leave block 2 untouched
        run_job(2, 255, 255, 1, 1'b1, w);
        check("oversize_keeps_elem", mem[2*BS+4], 32'd6);

        // zero-size matrix: header only
        set_name("ZERO");
        pay_q.delete();
        run_job(5, 0, 3, 1, 1'b1, w);

        // back-to-back jobs
        set_name("A");
        pay_q = '{32'd7};
        run_job(1, 1, 1, 1, 1'b0, w);
        set_name("B");
        pay_q = '{32'd8, 32'd9};
        run_job(3, 1, 2, 1, 1'b1, w2);
        check("b2b_accept_wait", w2, 1);
        check_block(1);
        check("b2b_elem_a", mem[BS+3], 32'd7);
        check("b2b_elem_b1", mem[3*BS+4], 32'd9);

        // reset during STREAM after 2 of 4 beats
        set_name("RST");
        pay_q.delete();
        for (int i = 0; i < 4; i++) pay_q.push_back(DW'($urandom));
        exp_q.delete();
        model_header(6 * BS, 2, 2);
        model_write(6 * BS + MW, pay_q[0]);
        model_write(6 * BS + MW + 1, pay_q[1]);
        matrix_id = 3'd6;
        actual_rows = 8'd2;
        actual_cols = 8'd2;
        for (int k = 0; k < 8; k++) matrix_name[k] = cur_name[k];
        write_request = 1'b1;
        @(posedge clk);
        #1;
        write_request = 1'b0;
        log_start  = log_q.size();
        done_start = done_cnt;
        sent = 0;
        cyc = 0;
        while (sent < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (writer_ready === 1'b1) begin
                data_valid = 1'b1;
                data_in    = pay_q[sent];
                sent++;
            end else begin
                data_valid = 1'b0;
            end
        end
        check("rst_mid_beats_sent", sent, 2);
        @(negedge clk);
        data_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_write_ready", write_ready, 1'b1);
        check("mid_rst_writer_ready", writer_ready, 1'b0);
        check("mid_rst_bram_we", bram_we, 1'b0);
        check("mid_rst_bram_addr", bram_addr, '0);
        check("mid_rst_bram_wdata", bram_wdata, '0);
        check("mid_rst_state", state_dbg, IDLE);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_no_done", done_cnt - done_start, 0);
        check_log(log_start, "mid_rst");
        check_block(6);
        run_job(6, 2, 2, 1, 1'b1, w);

        // random jobs
        for (int j = 0; j < 10; j++) begin
            id = $urandom_range(0, NBLK - 1);
            r  = $urandom_range(0, 20);
            c  = $urandom_range(0, 20);
            g  = $urandom_range(1, 3);
            for (int k = 0; k < 8; k++) cur_name[k] = 8'($urandom);
            pay_q.delete();
            for (int i = 0; i < r * c; i++) pay_q.push_back(DW'($urandom));
            run_job(id, r, c, g, 1'b1, w);
        end

`ifdef MATRIX_WRITER_ZERO_FILL_EN
        set_name("FULL");
        pay_q.delete();
        for (int i = 0; i < BS - MW; i++) pay_q.push_back(DW'($urandom) | 1);
        run_job(7, 11, 23, 1, 1'b1, w);
        pay_q = '{32'd5};
        run_job(7, 1, 1, 1, 1'b1, w);
        w2 = 0;
        for (int a = 4; a < BS; a++) if (mem[7*BS+a] !== '0) w2++;
        check("zero_fill_tail", w2, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matrix_block_writer.md
Name: matrix_block_writer

Overview:
- Downstream stage of every matrix operator (scalar mul, add, transpose, ...).
- Accepts a write-request handshake carrying destination ID, dimensions and an 8-byte name, then a streamed payload.
- Commits everything into the shared matrix BRAM: a 3-word metadata header followed by row-major elements in block `matrix_id`.
- Signals completion with a single-cycle `write_done` pulse.

Parameters:
- DATA_WIDTH, MATRIX_DATA_WIDTH (32), element/word width.
- ADDR_WIDTH, MATRIX_ADDR_WIDTH, BRAM word address width.
- BLOCK_SIZE, MATRIX_BLOCK_SIZE, words per matrix block.
- META_WORDS, MATRIX_METADATA_WORDS (3), header words per block.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- write_request  in  1  operator requests a block write
- write_ready  out  1  writer idle, request may be accepted
- matrix_id  in  3  destination block ID
- actual_rows  in  8  row count
- actual_cols  in  8  column count
- matrix_name  in  8x8  name bytes [0:7]
- data_in  in  DATA_WIDTH  payload element
- data_valid  in  1  data_in valid
- writer_ready  out  1  writer accepting payload this cycle
- write_done  out  1  one-cycle completion pulse
- write_error  out  1  qualifies write_done; size overflow
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_WIDTH  BRAM write address
- bram_wdata  out  DATA_WIDTH  BRAM write data

Behaviour:
- Reset values:
  - write_ready = 1; writer_ready, write_done, write_error, bram_we = 0.
  - bram_addr and bram_wdata = 0.
  - State IDLE; all latched fields cleared.
- States and transitions:
  - IDLE → CHECK on write_request && write_ready. Latch id, rows, cols, name. Compute base = id*BLOCK_SIZE and words = rows*cols (16-bit, no overflow possible).
  - CHECK:
    - If words + META_WORDS > BLOCK_SIZE → ERR.
    - Else → META0.
  - ERR: write_done = 1 and write_error = 1 for one cycle, no BRAM writes, → IDLE.
  - META0: write base+0 ← {rows, cols, 16'h0}.
  - META1: write base+1 ← {name[0], name[1], name[2], name[3]}.
  - META2: write base+2 ← {name[4], name[5], name[6], name[7]}. → STREAM if words > 0, else → DONE.
  - STREAM:
    - writer_ready = 1 (combinational from state).
    - Each cycle with data_valid: write base+META_WORDS+idx ← data_in; idx++.
    - On the last word (idx+1 == words) → DONE.
  - DONE: write_done = 1 for one cycle, write_error = 0, → IDLE.
- write_ready = 1 only in IDLE (combinational). Requests in any other state are ignored, not queued.
- bram_we/addr/wdata are registered: each write appears on the BRAM port one cycle after the state/beat that generated it. bram_we is high for exactly 3 + words cycles per successful job.
- data_valid outside STREAM is ignored. No backpressure inside STREAM: every valid beat is accepted.
- Back-to-back jobs: a request asserted in the cycle DONE returns to IDLE is accepted on the next clock.
- Reset mid-operation: immediately returns to IDLE with reset output values. A partially written block is left as-is. No write_done is emitted.
- Zero-size matrix (rows or cols = 0): header is written, then DONE. 3 BRAM writes total.

Optional Feature:
- Macro: MATRIX_WRITER_ZERO_FILL_EN.
- Defined: after the last payload word, a FILL state writes 0 to every remaining address up to base+BLOCK_SIZE-1, one per cycle, before DONE. writer_ready = 0 during FILL.
- Undefined: FILL does not exist; untouched words keep their old contents.

Decomposition:
- matrix_op_defs_pkg holds MATRIX_DATA_WIDTH, MATRIX_ADDR_WIDTH, MATRIX_BLOCK_SIZE, MATRIX_METADATA_WORDS, and the new typedef matrix_writer_state_e (IDLE, CHECK, META0, META1, META2, STREAM, FILL, DONE, ERR).
- No sub-module: a single FSM with an address counter.
- Header packing is a package function pack_matrix_header(rows, cols).

Test Plan:
- Request id=2, 2x2, name "SRC", stream 3,6,9,12 back-to-back:
  - block 2 header = {8'd2, 8'd2, 16'h0}, 32'h53524300, 32'h0;
  - payload = 3,6,9,12;
  - exactly one write_done, write_error = 0.
- Same job with data_valid gapped (1 valid every 3 cycles): identical memory contents; write_done only after the 4th beat.
- Oversize: rows=cols=255 with BLOCK_SIZE smaller than 65028:
  - write_done with write_error = 1 at CHECK+1;
  - zero bram_we cycles; memory unchanged.
- 0x3 matrix at id=5: header written (3 bram_we pulses), write_done, no payload writes.
- Two back-to-back jobs (id=1 1x1 value 7, then id=3 1x2 values 8,9): both blocks correct; second request accepted the cycle after the first write_done.
- Deassert rst_n during STREAM after 2 of 4 beats:
  - outputs return to reset values asynchronously;
  - no write_done;
  - a new request afterwards completes normally.
- With MATRIX_WRITER_ZERO_FILL_EN: a 1x1 job into a pre-filled block leaves words 4..BLOCK_SIZE-1 = 0.
